jt12_wrseq: RTL and testbench

- Bus-initiator for the jt12 CPU write port.
- Accepts queued register writes (part, register, value) from a host-side stream, buffers them, and replays each one onto the chip's cs_n/wr_n/addr/din pins.
- Each replay is a status poll on busy (dout bit 7), an address write, then a data write.
- Sits between a soft CPU, a VGM player or a test sequencer and the jt12 instance, so upstream logic never handles chip timing.

---
 rtl/jt12_wrseq_pkg.sv | 25 ++
 rtl/jt12_wrfifo.sv | 49 ++++
 rtl/jt12_wrseq.sv | 159 +++++++++++++++
 tb/tb_jt12_wrseq.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_wrseq_pkg.sv
// jt12 write sequencer: shared types and FIFO entry layout.
// State encoding, entry field offsets, small constant helper.
package jt12_wrseq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POLL,
    ADDR,
    GAP,
    DATA,
    RECOVER
  } state_t;

  localparam int ENT_W  = 17;
  localparam int D_LSB  = 0;
  localparam int R_LSB  = 8;
  localparam int P_BIT  = 16;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/jt12_wrfifo.sv
// Generic synchronous FIFO, power-of-two depth, sync active-high rst.
// Ports: clk, rst, push/din in, pop in, full/empty/head out.
module jt12_wrfifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rp];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push)
                 - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/jt12_wrseq.sv
// Replays queued {part,reg,data} writes onto the jt12 CPU port.
// Ports: clk/rst/cen, req_* host stream, pending/timeout status,
// clr_timeout, ym_dout status in, ym_din/addr/cs_n/wr_n pins out.
module jt12_wrseq
  import jt12_wrseq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int WR_LEN  = 2,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_part,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_data,
  output logic       pending,
  output logic       timeout,
  input  logic       clr_timeout,
  input  logic [7:0] ym_dout,
  output logic [7:0] ym_din,
  output logic [1:0] ym_addr,
  output logic       ym_cs_n,
  output logic       ym_wr_n
);

  localparam int CW =
    $clog2(max3(WR_LEN, SETTLE, TIMEOUT) + 1);
  localparam logic [CW-1:0] WR_END = CW'(WR_LEN - 1);
  localparam logic [CW-1:0] ST_END = CW'(SETTLE - 1);
  localparam logic [CW-1:0] TO_END = CW'(TIMEOUT);

  state_t           st;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic             w_part;
  logic [7:0]       w_reg;
  logic [7:0]       w_data;
  logic             full;
  logic             empty;
  logic             pop;
  logic             busy;
  logic [ENT_W-1:0] head;
  logic [ENT_W-1:0] ent;
  logic             unused_dout;

  assign busy        = ym_dout[7];
  assign unused_dout = ^ym_dout[6:0];
  assign cnt_inc     = cnt + CW'(1);
  assign ent         = {req_part, req_reg, req_data};
  assign req_ready   = ~full;
  assign pending     = ~empty | (st != IDLE);
  assign pop = cen & (st == DATA) & (cnt == WR_END);

  jt12_wrfifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .din   (ent),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= '0;
      w_part  <= 1'b0;
      w_reg   <= '0;
      w_data  <= '0;
      timeout <= 1'b0;
      ym_cs_n <= 1'b1;
      ym_wr_n <= 1'b1;
      ym_addr <= '0;
      ym_din  <= '0;
    end else begin
      if (clr_timeout) timeout <= 1'b0;
      if (cen) begin
        unique case (st)
          IDLE: begin
            if (!empty) begin
              st      <= POLL;
              cnt     <= '0;
              w_part  <= head[P_BIT];
              w_reg   <= head[R_LSB +: 8];
              w_data  <= head[D_LSB +: 8];
              ym_cs_n <= 1'b0;
              ym_wr_n <= 1'b1;
              ym_addr <= {head[P_BIT], 1'b0};
            end
          end
          POLL: begin
            if (!busy || cnt_inc == TO_END) begin
              // forced write: placed after the clear so set wins
              if (busy) timeout <= 1'b1;
              st      <= ADDR;
              cnt     <= '0;
              ym_cs_n <= 1'b0;
              ym_wr_n <= 1'b0;
              ym_addr <= {w_part, 1'b0};
              ym_din  <= w_reg;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ADDR: begin
            if (cnt == WR_END) begin
              st      <= GAP;
              cnt     <= '0;
              ym_cs_n <= 1'b1;
              ym_wr_n <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          GAP: begin
            st      <= DATA;
            cnt     <= '0;
            ym_cs_n <= 1'b0;
            ym_wr_n <= 1'b0;
            ym_addr <= {w_part, 1'b1};
            ym_din  <= w_data;
          end
          DATA: begin
            if (cnt == WR_END) begin
              st      <= RECOVER;
              cnt     <= '0;
              ym_cs_n <= 1'b1;
              ym_wr_n <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          RECOVER: begin
            if (cnt == ST_END) begin
              st  <= IDLE;
              cnt <= '0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            st  <= IDLE;
            cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt12_wrseq.sv
// Directed bench for jt12_wrseq: vector table for a single write,
// plus sequences for queueing, busy polling, timeout, cen and reset.
module tb_jt12_wrseq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic       req_valid;
  logic       req_ready;
  logic       req_part;
  logic [7:0] req_reg;
  logic [7:0] req_data;
  logic       pending;
  logic       timeout;
  logic       clr_timeout;
  logic [7:0] ym_dout;
  logic [7:0] ym_din;
  logic [1:0] ym_addr;
  logic       ym_cs_n;
  logic       ym_wr_n;

  jt12_wrseq dut (
    .clk         (clk),
    .rst         (rst),
    .cen         (cen),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_part    (req_part),
    .req_reg     (req_reg),
    .req_data    (req_data),
    .pending     (pending),
    .timeout     (timeout),
    .clr_timeout (clr_timeout),
    .ym_dout     (ym_dout),
    .ym_din      (ym_din),
    .ym_addr     (ym_addr),
    .ym_cs_n     (ym_cs_n),
    .ym_wr_n     (ym_wr_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cs;
    logic       wr;
    logic       pend;
    logic       ca;
    logic [1:0] a;
    logic       cd;
    logic [7:0] d;
  } row_t;

  typedef struct {
    logic       p;
    logic [7:0] r;
    logic [7:0] d;
  } ent_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         div3 = 1'b0;
  logic       prev_wr = 1'b1;
  logic [9:0] wq[$];
  row_t       t1[12];
  ent_t       ents[5];

  function automatic row_t mk(logic cs, logic wr, logic pend,
                              logic ca, logic [1:0] a,
                              logic cd, logic [7:0] d);
    row_t r;
    r.cs = cs; r.wr = wr; r.pend = pend;
    r.ca = ca; r.a = a; r.cd = cd; r.d = d;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    cen = div3 ? (cyc % 3 == 0) : 1'b1;
    if (prev_wr && !ym_wr_n) wq.push_back({ym_addr, ym_din});
    prev_wr = ym_wr_n;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push1(input logic p, input logic [7:0] r,
                       input logic [7:0] d);
    req_part = p; req_reg = r; req_data = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 2000 && pending; i++) tick();
    chk(name, pending, 1'b0);
  endtask

  initial begin
    int         idx;
    bit         acc;
    bit         seen4;
    bit         flag;
    logic       cen_edge;
    logic [11:0] snap;
    int         nochg;
    int         runs_l[$];
    logic       runs_v[$];
    int         rl;
    logic       rv;
    int         j;
    logic [9:0] e;

    t1[0]  = mk(1, 1, 1, 1, 2'd0, 1, 8'h00);
    t1[1]  = mk(0, 1, 1, 1, 2'd0, 0, 8'h00);
    t1[2]  = mk(0, 0, 1, 1, 2'd0, 1, 8'h28);
    t1[3]  = mk(0, 0, 1, 1, 2'd0, 1, 8'h28);
    t1[4]  = mk(1, 1, 1, 0, 2'd0, 1, 8'h28);
    t1[5]  = mk(0, 0, 1, 1, 2'd1, 1, 8'hF0);
    t1[6]  = mk(0, 0, 1, 1, 2'd1, 1, 8'hF0);
    t1[7]  = mk(1, 1, 1, 0, 2'd0, 0, 8'h00);
    t1[8]  = mk(1, 1, 1, 0, 2'd0, 0, 8'h00);
    t1[9]  = mk(1, 1, 1, 0, 2'd0, 0, 8'h00);
    t1[10] = mk(1, 1, 1, 0, 2'd0, 0, 8'h00);
    t1[11] = mk(1, 1, 0, 0, 2'd0, 0, 8'h00);

    ents[0] = '{1'b0, 8'h28, 8'hF0};
    ents[1] = '{1'b1, 8'h30, 8'h11};
    ents[2] = '{1'b0, 8'hA4, 8'h22};
    ents[3] = '{1'b1, 8'hB4, 8'hC0};
    ents[4] = '{1'b0, 8'h28, 8'h01};

    rst = 1'b1; cen = 1'b1; req_valid = 1'b0;
    req_part = 1'b0; req_reg = '0; req_data = '0;
    clr_timeout = 1'b0; ym_dout = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_pins", {ym_cs_n, ym_wr_n, ym_addr, ym_din},
        {1'b1, 1'b1, 2'd0, 8'h00});
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_pending", pending, 1'b0);
    chk("rst_timeout", timeout, 1'b0);

    // single write, cycle by cycle against the table
    push1(1'b0, 8'h28, 8'hF0);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      chk($sformatf("t1_row%0d", i),
          {ym_cs_n, ym_wr_n, pending,
           t1[i].ca ? ym_addr : 2'd0,
           t1[i].cd ? ym_din : 8'h00},
          {t1[i].cs, t1[i].wr, t1[i].pend,
           t1[i].ca ? t1[i].a : 2'd0,
           t1[i].cd ? t1[i].d : 8'h00});
    end

    // five back-to-back pushes into a 4-deep FIFO
    wq.delete();
    idx = 0; seen4 = 1'b0;
    for (int c = 0; c < 500 && idx < 5; c++) begin
      req_part = ents[idx].p;
      req_reg  = ents[idx].r;
      req_data = ents[idx].d;
      req_valid = 1'b1;
      acc = req_ready;
      tick();
      if (acc) idx++;
      if (idx == 4 && !seen4) begin
        seen4 = 1'b1;
        chk("full_ready", req_ready, 1'b0);
      end
    end
    req_valid = 1'b0;
    chk("t2_accepted", idx, 5);
    wait_idle("t2_idle");
    chk("t2_nwrites", wq.size(), 10);
    for (int i = 0; i < 5; i++) begin
      e = (wq.size() > 2*i) ? wq[2*i] : 10'h3FF;
      chk($sformatf("t2_addr%0d", i), e,
          {ents[i].p, 1'b0, ents[i].r});
      e = (wq.size() > 2*i+1) ? wq[2*i+1] : 10'h3FF;
      chk($sformatf("t2_data%0d", i), e,
          {ents[i].p, 1'b1, ents[i].d});
    end

    // busy for 10 poll ticks
    ym_dout = 8'h80;
    push1(1'b0, 8'h40, 8'h7F);
    tick();
    chk("t3_poll", {ym_cs_n, ym_wr_n}, 2'b01);
    flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!ym_wr_n) flag = 1'b1;
    end
    chk("t3_early_wr", flag, 1'b0);
    ym_dout = 8'h00;
    tick();
    chk("t3_wr_fall", ym_wr_n, 1'b0);
    chk("t3_timeout", timeout, 1'b0);
    wait_idle("t3_idle");

    // stuck busy: forced write after 255 ticks
    ym_dout = 8'h80;
    push1(1'b0, 8'h41, 8'h01);
    tick();
    flag = 1'b0;
    for (int i = 0; i < 254; i++) begin
      tick();
      if (!ym_wr_n) flag = 1'b1;
    end
    chk("t4_early_wr", flag, 1'b0);
    chk("t4_to_early", timeout, 1'b0);
    tick();
    chk("t4_wr_fall", ym_wr_n, 1'b0);
    chk("t4_to_set", timeout, 1'b1);
    wait_idle("t4_idle");
    chk("t4_to_sticky", timeout, 1'b1);
    clr_timeout = 1'b1;
    tick();
    clr_timeout = 1'b0;
    chk("t4_to_clr", timeout, 1'b0);
    clr_timeout = 1'b1;
    push1(1'b1, 8'h42, 8'h02);
    tick();
    for (int i = 0; i < 255; i++) tick();
    clr_timeout = 1'b0;
    chk("t4_set_wins", timeout, 1'b1);
    ym_dout = 8'h00;
    wait_idle("t4_idle2");

    // cen 1-of-3
    div3 = 1'b1;
    cen = 1'b0;
    push1(1'b0, 8'h28, 8'hF0);
    nochg = 0;
    rv = ym_wr_n; rl = 0;
    snap = {ym_cs_n, ym_wr_n, ym_addr, ym_din};
    for (int c = 0; c < 300 && pending; c++) begin
      cen_edge = cen;
      tick();
      if (!cen_edge &&
          {ym_cs_n, ym_wr_n, ym_addr, ym_din} != snap)
        nochg++;
      snap = {ym_cs_n, ym_wr_n, ym_addr, ym_din};
      if (ym_wr_n == rv) rl++;
      else begin
        runs_v.push_back(rv); runs_l.push_back(rl + 1);
        rv = ym_wr_n; rl = 0;
      end
    end
    chk("t5_idle", pending, 1'b0);
    chk("t5_cen0_change", nochg, 0);
    j = -1;
    for (int i = 0; i < runs_v.size(); i++)
      if (j < 0 && runs_v[i] == 1'b0) j = i;
    if (j < 0 || runs_v.size() < j + 3) begin
      chk("t5_runs", runs_v.size(), 3);
    end else begin
      chk("t5_addr_w", runs_l[j], 6);
      chk("t5_gap_w", runs_l[j+1], 3);
      chk("t5_data_w", runs_l[j+2], 6);
    end
    div3 = 1'b0;
    cen = 1'b1;
    tick();

    // reset in DATA discards the queue
    push1(1'b0, 8'h50, 8'hAA);
    push1(1'b1, 8'h51, 8'hBB);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_in_data", {ym_cs_n, ym_wr_n, ym_addr, ym_din},
        {1'b0, 1'b0, 2'd1, 8'hAA});
    rst = 1'b1;
    tick();
    chk("t6_pins", {ym_cs_n, ym_wr_n, ym_addr, ym_din},
        {1'b1, 1'b1, 2'd0, 8'h00});
    chk("t6_ready", req_ready, 1'b1);
    chk("t6_pending", pending, 1'b0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("t6_after", {pending, ym_cs_n}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
